// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
interface icache_responder_if;
    // datapath fetch port
    logic        dpif_imemREN;
    logic [31:0] dpif_imemaddr;
    logic        dpif_ihit;
    logic [31:0] dpif_imemload;
    // memory controller instruction port
    logic        ccif_iREN;
    logic [31:0] ccif_iaddr;
    logic        ccif_iwait;
    logic [31:0] ccif_iload;

    // cache side
    modport slave (
        input  dpif_imemREN, dpif_imemaddr, ccif_iwait, ccif_iload,
        output dpif_ihit, dpif_imemload, ccif_iREN, ccif_iaddr
    );

    // environment side (datapath + memory controller)
    modport master (
        output dpif_imemREN, dpif_imemaddr, ccif_iwait, ccif_iload,
        input  dpif_ihit, dpif_imemload, ccif_iREN, ccif_iaddr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only, one-word-per-line instruction cache.
// Hits answer in the same cycle; misses fetch one word from memory.
module icache_responder #(
    parameter int unsigned SETS = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    icache_responder_if.slave     bus,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [31:0]        data_arr [SETS];
    logic [31:0]        lat_addr;
    logic [31:0]        last_load;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               hit;

    // Address split and zero-latency hit detection (only while idle).
    always_comb begin
        req_idx = bus.dpif_imemaddr[IDX_W+1:2];
        req_tag = bus.dpif_imemaddr[31:IDX_W+2];
        lat_idx = lat_addr[IDX_W+1:2];
        lat_tag = lat_addr[31:IDX_W+2];
        hit     = (state == IDLE) && bus.dpif_imemREN && valid[req_idx]
                  && (tag_arr[req_idx] == req_tag);
    end

    // Output drive; imemload holds the last hit word so it reads 0 until the first hit.
    always_comb begin
        bus.dpif_ihit     = hit;
        bus.dpif_imemload = hit ? data_arr[req_idx] : last_load;
        bus.ccif_iREN     = (state == FETCH);
        bus.ccif_iaddr    = (state == FETCH) ? (lat_addr & 32'hFFFF_FFFC) : '0;
    end

    // Fill FSM, line array update and hit/miss counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            lat_addr   <= '0;
            last_load  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        hit_count <= hit_count + 32'd1;
                        last_load <= data_arr[req_idx];
                    end else if (bus.dpif_imemREN) begin
                        lat_addr <= bus.dpif_imemaddr;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!bus.ccif_iwait) begin
                        data_arr[lat_idx] <= bus.ccif_iload;
                        tag_arr[lat_idx]  <= lat_tag;
                        valid[lat_idx]    <= 1'b1;
                        miss_count        <= miss_count + 32'd1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder (SETS = 16).
module tb_icache_responder;
    logic        clk;
    logic        nrst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          checks;
    int          failures;

    icache_responder_if bif ();

    icache_responder #(.SETS(16)) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .bus        (bif.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // 10 ns clock, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present address a in IDLE, expect a miss, then serve w wait cycles and data d.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int w);
        bif.dpif_imemREN  = 1'b1;
        bif.dpif_imemaddr = a;
        bif.ccif_iwait    = 1'b1;
        bif.ccif_iload    = 32'hDEAD_BEEF;
        #1;
        chk("miss_ihit", {31'd0, bif.dpif_ihit}, 32'd0);
        chk("miss_iren_idle", {31'd0, bif.ccif_iREN}, 32'd0);
        tick();
        for (int i = 0; i <= w; i++) begin
            bif.ccif_iwait = (i < w);
            bif.ccif_iload = (i < w) ? 32'hDEAD_BEEF : d;
            #1;
            chk("fetch_iren", {31'd0, bif.ccif_iREN}, 32'd1);
            chk("fetch_iaddr", bif.ccif_iaddr, a & 32'hFFFF_FFFC);
            chk("fetch_ihit", {31'd0, bif.dpif_ihit}, 32'd0);
            tick();
        end
        bif.ccif_iwait = 1'b1;
        bif.ccif_iload = 32'hDEAD_BEEF;
        #1;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        nrst              = 1'b0;
        bif.dpif_imemREN  = 1'b0;
        bif.dpif_imemaddr = '0;
        bif.ccif_iwait    = 1'b1;
        bif.ccif_iload    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ihit", {31'd0, bif.dpif_ihit}, 32'd0);
        chk("rst_iren", {31'd0, bif.ccif_iREN}, 32'd0);
        chk("rst_iaddr", bif.ccif_iaddr, 32'd0);
        chk("rst_imemload", bif.dpif_imemload, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        nrst = 1'b1;

        // Cold miss on 0x40 with 3 wait cycles, then hit
        do_miss(32'h0000_0040, 32'h2401_0005, 3);
        chk("t1_ihit", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t1_load", bif.dpif_imemload, 32'h2401_0005);
        chk("t1_misses", miss_count, 32'd1);
        tick();
        chk("t1_hits", hit_count, 32'd1);

        // Five back-to-back hits on 0x40 (first of them continues the t1 request)
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_ihit", {31'd0, bif.dpif_ihit}, 32'd1);
            chk("t2_iren", {31'd0, bif.ccif_iREN}, 32'd0);
            tick();
        end
        chk("t2_hits", hit_count, 32'd6);
        chk("t2_misses", miss_count, 32'd1);

        // Conflict: 0x80 evicts 0x40 (index 0), then 0x40 refills
        do_miss(32'h0000_0080, 32'h1111_2222, 1);
        chk("t3_load80", bif.dpif_imemload, 32'h1111_2222);
        tick();
        do_miss(32'h0000_0040, 32'h2401_0005, 0);
        chk("t3_ihit40", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t3_load40", bif.dpif_imemload, 32'h2401_0005);
        chk("t3_misses", miss_count, 32'd3);
        tick();
        chk("t3_hits", hit_count, 32'd8);

        // Redirect mid-fill: miss on 0x104 (index 1), switch to cached 0x40
        bif.dpif_imemaddr = 32'h0000_0104;
        bif.ccif_iwait    = 1'b1;
        #1;
        chk("t4_miss", {31'd0, bif.dpif_ihit}, 32'd0);
        tick();
        chk("t4_iaddr1", bif.ccif_iaddr, 32'h0000_0104);
        tick();
        bif.dpif_imemaddr = 32'h0000_0040;
        #1;
        chk("t4_nohit_fetch", {31'd0, bif.dpif_ihit}, 32'd0);
        chk("t4_iaddr2", bif.ccif_iaddr, 32'h0000_0104);
        tick();
        bif.ccif_iwait = 1'b0;
        bif.ccif_iload = 32'h3333_4444;
        #1;
        chk("t4_nohit_last", {31'd0, bif.dpif_ihit}, 32'd0);
        chk("t4_iaddr3", bif.ccif_iaddr, 32'h0000_0104);
        tick();
        bif.ccif_iwait = 1'b1;
        bif.ccif_iload = 32'hDEAD_BEEF;
        #1;
        chk("t4_hit40", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t4_load40", bif.dpif_imemload, 32'h2401_0005);
        chk("t4_misses", miss_count, 32'd4);
        tick();
        bif.dpif_imemaddr = 32'h0000_0104;
        #1;
        chk("t4_hit104", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t4_iren104", {31'd0, bif.ccif_iREN}, 32'd0);
        chk("t4_load104", bif.dpif_imemload, 32'h3333_4444);
        tick();
        chk("t4_hits", hit_count, 32'd10);

        // Unaligned addresses: 0x43 hits the 0x40 word; 0x206 fills with aligned iaddr
        bif.dpif_imemaddr = 32'h0000_0043;
        #1;
        chk("t6_hit43", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t6_load43", bif.dpif_imemload, 32'h2401_0005);
        chk("t6_iaddr", bif.ccif_iaddr, 32'd0);
        tick();
        do_miss(32'h0000_0206, 32'h7777_8888, 2);
        chk("t6_hit206", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t6_load206", bif.dpif_imemload, 32'h7777_8888);
        tick();
        chk("t6_hits", hit_count, 32'd12);
        chk("t6_misses", miss_count, 32'd5);

        // Reset in the second FETCH cycle, with memory ready on that same edge
        bif.dpif_imemaddr = 32'h0000_0308;
        bif.ccif_iwait    = 1'b1;
        #1;
        chk("t5_miss", {31'd0, bif.dpif_ihit}, 32'd0);
        tick();
        tick();
        nrst           = 1'b0;
        bif.ccif_iwait = 1'b0;
        bif.ccif_iload = 32'h5555_5555;
        #1;
        chk("t5_iren_pre", {31'd0, bif.ccif_iREN}, 32'd1);
        tick();
        chk("t5_iren_post", {31'd0, bif.ccif_iREN}, 32'd0);
        chk("t5_ihit_post", {31'd0, bif.dpif_ihit}, 32'd0);
        chk("t5_hits", hit_count, 32'd0);
        chk("t5_misses", miss_count, 32'd0);
        nrst           = 1'b1;
        bif.ccif_iwait = 1'b1;
        bif.dpif_imemaddr = 32'h0000_0040;
        #1;
        chk("t5_40_invalid", {31'd0, bif.dpif_ihit}, 32'd0);
        bif.dpif_imemREN = 1'b0;
        tick();
        do_miss(32'h0000_0308, 32'h6666_0001, 1);
        chk("t5_refill_hit", {31'd0, bif.dpif_ihit}, 32'd1);
        chk("t5_refill_load", bif.dpif_imemload, 32'h6666_0001);
        chk("t5_refill_misses", miss_count, 32'd1);
        tick();
        chk("t5_refill_hits", hit_count, 32'd1);

        // Idle request line: no hit, no counting
        bif.dpif_imemREN = 1'b0;
        #1;
        chk("idle_ihit", {31'd0, bif.dpif_ihit}, 32'd0);
        tick();
        chk("idle_hits", hit_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
